// File: rtl/sdram_dq_datapath.sv
// sdram_dq_datapath: SDRAM DQ-bus data path between the command FSM and the
// wr/rd FIFOs. Drives DQ/DQM for write bursts and captures read bursts
// CAS_LAT cycles after the READ command, with gapless back-to-back reads.
// Beat counting is local, so the command FSM only pulses wr_start/rd_start.
// Optional feature macro: SDRAM_DQ_DQM_EN. When it is defined, write bytes
// are masked via DQM from sys_wbe. When it is undefined, DQM stays 0 and
// every byte is written.
module sdram_dq_datapath #(
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 8,
  parameter int CAS_LAT   = 2,
  parameter int MASK_W    = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_start,
  input  logic              rd_start,
  input  logic [DATA_W-1:0] sys_wdata,
  input  logic [MASK_W-1:0] sys_wbe,
  output logic              sys_wreq,
  output logic [DATA_W-1:0] sys_rdata,
  output logic              sys_rvalid,
  inout  wire  [DATA_W-1:0] sdram_dq,
  output logic [MASK_W-1:0] sdram_dqm,
  output logic              busy,
  output logic              wr_done,
  output logic              err_collision
);

  localparam int CAP_W = CAS_LAT + BURST_LEN + 1;
  localparam int REM_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic {IDLE, WR} wr_state_e;

  wr_state_e         state, state_d;
  logic [REM_W-1:0]  rem, rem_d;
  logic [DATA_W-1:0] dq_out, dq_out_d;
  logic              dq_oe, dq_oe_d;
  logic [MASK_W-1:0] dqm_q, dqm_d;
  logic              wr_done_d;
  logic [CAP_W-1:0]  cap, cap_d;
  logic [CAP_W-1:0]  rd_win;
  logic [MASK_W-1:0] mask_in;
  logic              rd_acc, wr_acc;

  // Capture slots a read occupies, counted from the edge that accepts it.
  assign rd_win = {{BURST_LEN{1'b1}}, {(CAS_LAT + 1){1'b0}}};

`ifdef SDRAM_DQ_DQM_EN
  assign mask_in = ~sys_wbe;
`else
  logic unused_wbe;
  assign unused_wbe = ^sys_wbe;
  assign mask_in    = '0;
`endif

  // A read wins any tie with a write; a read must not overlap pending slots.
  assign rd_acc = rd_start && (state == IDLE) && ((cap & rd_win) == '0);
  assign wr_acc = wr_start && (state == IDLE) && (cap == '0) && !rd_start;

  assign busy      = (state == WR) || (cap != '0);
  assign sdram_dq  = dq_oe ? dq_out : {DATA_W{1'bz}};
  assign sdram_dqm = dqm_q;

  // Write FSM next-state, bus load and FIFO pop.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state;
    rem_d     = rem;
    dq_out_d  = dq_out;
    dq_oe_d   = dq_oe;
    dqm_d     = dqm_q;
    wr_done_d = 1'b0;
    sys_wreq  = 1'b0;
    unique case (state)
      IDLE: begin
        if (wr_acc) begin
          sys_wreq = 1'b1;
          dq_out_d = sys_wdata;
          dqm_d    = mask_in;
          dq_oe_d  = 1'b1;
          rem_d    = REM_W'(BURST_LEN - 1);
          state_d  = WR;
        end
      end
      WR: begin
        if (rem != '0) begin
          sys_wreq = 1'b1;
          dq_out_d = sys_wdata;
          dqm_d    = mask_in;
          rem_d    = rem - REM_W'(1);
        end else begin
          dq_oe_d   = 1'b0;
          dqm_d     = '0;
          wr_done_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read capture schedule: shift one slot per edge, merge an accepted read.
  always_comb begin
    cap_d = cap >> 1;
    if (rd_acc) cap_d = (cap | rd_win) >> 1;
  end

  // Write FSM registers and bus drivers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rem     <= '0;
      dq_out  <= '0;
      dq_oe   <= 1'b0;
      dqm_q   <= '0;
      wr_done <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state   <= state_d;
      rem     <= rem_d;
      dq_out  <= dq_out_d;
      dq_oe   <= dq_oe_d;
      dqm_q   <= dqm_d;
      wr_done <= wr_done_d;
    end
  end

  // Read capture vector and captured data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap        <= '0;
      sys_rdata  <= '0;
      sys_rvalid <= 1'b0;
    end else begin
      cap        <= cap_d;
      sys_rvalid <= cap[0];
      if (cap[0]) sys_rdata <= sdram_dq;
    end
  end

  // Sticky collision flag: any rejected start sets it until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_collision <= 1'b0;
    end else if ((wr_start && !wr_acc) || (rd_start && !rd_acc)) begin
      err_collision <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_dq_datapath.sv
// Self-checking bench for sdram_dq_datapath (DATA_W=16, BURST_LEN=4,
// CAS_LAT=2). Expected write beats and read words are pushed into queues as
// stimulus is driven and popped when the DUT puts a beat on the bus or
// raises sys_rvalid. DQM expectations follow SDRAM_DQ_DQM_EN.
module tb_sdram_dq_datapath;

  localparam int DATA_W = 16;
  localparam int BL     = 4;
  localparam int CAS    = 2;
  localparam int MASK_W = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_start = 1'b0;
  logic              rd_start = 1'b0;
  logic [DATA_W-1:0] sys_wdata = '0;
  logic [MASK_W-1:0] sys_wbe = '1;
  logic              sys_wreq;
  logic [DATA_W-1:0] sys_rdata;
  logic              sys_rvalid;
  wire  [DATA_W-1:0] sdram_dq;
  logic [MASK_W-1:0] sdram_dqm;
  logic              busy;
  logic              wr_done;
  logic              err_collision;

  logic              tb_oe = 1'b0;
  logic [DATA_W-1:0] tb_dq = '0;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] exp_wr_data[$];
  logic [MASK_W-1:0] exp_wr_dqm[$];
  logic [DATA_W-1:0] exp_rd[$];

  assign sdram_dq = tb_oe ? tb_dq : {DATA_W{1'bz}};

  always #5 clk = ~clk;

  sdram_dq_datapath #(
    .DATA_W(DATA_W), .BURST_LEN(BL), .CAS_LAT(CAS)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_start(wr_start), .rd_start(rd_start),
    .sys_wdata(sys_wdata), .sys_wbe(sys_wbe), .sys_wreq(sys_wreq),
    .sys_rdata(sys_rdata), .sys_rvalid(sys_rvalid),
    .sdram_dq(sdram_dq), .sdram_dqm(sdram_dqm),
    .busy(busy), .wr_done(wr_done), .err_collision(err_collision)
  );

  function automatic logic [MASK_W-1:0] exp_mask(input logic [MASK_W-1:0] be);
`ifdef SDRAM_DQ_DQM_EN
    return ~be;
`else
    return '0;
`endif
  endfunction

  task automatic apply_reset();
    wr_start = 1'b0;
    rd_start = 1'b0;
    tb_oe    = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (sys_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b want 0", sys_rvalid); end
    checks++; if (sys_rdata !== '0) begin errors++; $display("FAIL rst_rdata: got %h want 0", sys_rdata); end
    checks++; if (wr_done !== 1'b0) begin errors++; $display("FAIL rst_wr_done: got %b want 0", wr_done); end
    checks++; if (err_collision !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err_collision); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (dut.dq_oe !== 1'b0) begin errors++; $display("FAIL rst_dq_oe: got %b want 0", dut.dq_oe); end
    checks++; if (sdram_dqm !== '0) begin errors++; $display("FAIL rst_dqm: got %b want 0", sdram_dqm); end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    int done_seen;
    sys_wdata = 16'hBEEF;
    sys_wbe   = 2'b10;
    wr_start  = 1'b1;
    @(posedge clk);
    #1 wr_start = 1'b0;
    checks++; if (dut.dq_oe !== 1'b1) begin errors++; $display("FAIL midrst_oe_before: got %b want 1", dut.dq_oe); end
    checks++; if (sdram_dqm !== exp_mask(2'b10)) begin errors++; $display("FAIL midrst_dqm_before: got %b want %b", sdram_dqm, exp_mask(2'b10)); end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (dut.dq_oe !== 1'b0) begin errors++; $display("FAIL midrst_oe: got %b want 0", dut.dq_oe); end
    checks++; if (sdram_dqm !== '0) begin errors++; $display("FAIL midrst_dqm: got %b want 0", sdram_dqm); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    #1 rst = 1'b0;
    done_seen = 0;
    for (int c = 0; c < BL + 3; c++) begin
      @(posedge clk);
      #1 if (wr_done === 1'b1 || dut.dq_oe === 1'b1) done_seen++;
    end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d active cycles want 0", done_seen); end
  endtask

  task automatic test_write();
    logic [DATA_W-1:0] w [4];
    logic [MASK_W-1:0] be[4];
    int fidx;
    logic wq;
    w  = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    be = '{2'b11, 2'b11, 2'b01, 2'b11};
    for (int i = 0; i < BL; i++) begin
      exp_wr_data.push_back(w[i]);
      exp_wr_dqm.push_back(exp_mask(be[i]));
    end
    fidx = 0;
    for (int c = 0; c < BL + 3; c++) begin
      sys_wdata = (fidx < 4) ? w[fidx]  : '0;
      sys_wbe   = (fidx < 4) ? be[fidx] : '1;
      wr_start  = (c == 0);
      #1;
      checks++; if (sys_wreq !== (c < BL)) begin errors++; $display("FAIL wr_wreq c%0d: got %b want %b", c, sys_wreq, (c < BL)); end
      wq = sys_wreq;
      @(posedge clk);
      if (wq) fidx++;
      #1;
      if (dut.dq_oe === 1'b1) begin
        if (exp_wr_data.size() == 0) begin
          checks++; errors++; $display("FAIL wr_extra_beat c%0d: got data %h want no beat", c, sdram_dq);
        end else begin
          logic [DATA_W-1:0] ed;
          logic [MASK_W-1:0] em;
          ed = exp_wr_data.pop_front();
          em = exp_wr_dqm.pop_front();
          checks++; if (sdram_dq !== ed) begin errors++; $display("FAIL wr_data c%0d: got %h want %h", c, sdram_dq, ed); end
          checks++; if (sdram_dqm !== em) begin errors++; $display("FAIL wr_dqm c%0d: got %b want %b", c, sdram_dqm, em); end
        end
      end else begin
        checks++; if (sdram_dqm !== '0) begin errors++; $display("FAIL wr_idle_dqm c%0d: got %b want 0", c, sdram_dqm); end
      end
      checks++; if (wr_done !== (c == BL)) begin errors++; $display("FAIL wr_done c%0d: got %b want %b", c, wr_done, (c == BL)); end
    end
    wr_start = 1'b0;
    checks++; if (exp_wr_data.size() != 0) begin errors++; $display("FAIL wr_missing_beats: got %0d left want 0", exp_wr_data.size()); end
    checks++; if (fidx !== BL) begin errors++; $display("FAIL wr_pops: got %0d want %0d", fidx, BL); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_end: got %b want 0", busy); end
    checks++; if (err_collision !== 1'b0) begin errors++; $display("FAIL wr_err: got %b want 0", err_collision); end
    exp_wr_data.delete();
    exp_wr_dqm.delete();
  endtask

  // Read at cycle 0, optional second read at cycle sb (accepted when b_acc),
  // optional simultaneous wr_start at cycle 0.
  task automatic test_reads(input int sb, input bit b_acc, input bit with_wr, input logic exp_err);
    logic [DATA_W-1:0] drv[32];
    bit drv_en[32];
    int ncyc, n, first, last, exp_n, oe_seen, wreq_seen;
    for (int i = 0; i < 32; i++) begin drv[i] = '0; drv_en[i] = 1'b0; end
    for (int i = 0; i < BL; i++) begin
      drv[CAS + 1 + i] = 16'hA000 + 16'(i);
      drv_en[CAS + 1 + i] = 1'b1;
      exp_rd.push_back(16'hA000 + 16'(i));
    end
    if (sb > 0 && b_acc) begin
      for (int i = 0; i < BL; i++) begin
        drv[sb + CAS + 1 + i] = 16'hB000 + 16'(i);
        drv_en[sb + CAS + 1 + i] = 1'b1;
        exp_rd.push_back(16'hB000 + 16'(i));
      end
    end
    exp_n = exp_rd.size();
    ncyc  = ((sb > 0) ? sb : 0) + CAS + BL + 4;
    n = 0; first = -1; last = -1; oe_seen = 0; wreq_seen = 0;
    for (int c = 0; c < ncyc; c++) begin
      rd_start = (c == 0) || (c == sb);
      wr_start = with_wr && (c == 0);
      tb_oe    = drv_en[c];
      tb_dq    = drv[c];
      #1 if (sys_wreq === 1'b1) wreq_seen++;
      @(posedge clk);
      #1;
      if (dut.dq_oe === 1'b1) oe_seen++;
      if (sys_rvalid === 1'b1) begin
        n++;
        if (first < 0) first = c;
        last = c;
        if (exp_rd.size() == 0) begin
          checks++; errors++; $display("FAIL rd_extra c%0d: got %h want no beat", c, sys_rdata);
        end else begin
          logic [DATA_W-1:0] er;
          er = exp_rd.pop_front();
          checks++; if (sys_rdata !== er) begin errors++; $display("FAIL rd_data c%0d: got %h want %h", c, sys_rdata, er); end
        end
      end
    end
    rd_start = 1'b0;
    wr_start = 1'b0;
    tb_oe    = 1'b0;
    checks++; if (n !== exp_n) begin errors++; $display("FAIL rd_beats: got %0d want %0d", n, exp_n); end
    checks++; if (first !== CAS + 1) begin errors++; $display("FAIL rd_latency: got %0d want %0d", first, CAS + 1); end
    checks++; if (last - first + 1 !== exp_n) begin errors++; $display("FAIL rd_gapless: got span %0d want %0d", last - first + 1, exp_n); end
    checks++; if (oe_seen !== 0) begin errors++; $display("FAIL rd_bus_driven: got %0d cycles want 0", oe_seen); end
    checks++; if (wreq_seen !== 0) begin errors++; $display("FAIL rd_wreq: got %0d pops want 0", wreq_seen); end
    checks++; if (err_collision !== exp_err) begin errors++; $display("FAIL rd_err: got %b want %b", err_collision, exp_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_busy_end: got %b want 0", busy); end
    exp_rd.delete();
  endtask

  // A write during a pending read is rejected and pops nothing.
  task automatic test_wr_during_read();
    int pops;
    pops = 0;
    for (int c = 0; c < CAS + BL + 3; c++) begin
      rd_start = (c == 0);
      wr_start = (c == 2);
      #1 if (sys_wreq === 1'b1) pops++;
      @(posedge clk);
      #1;
    end
    wr_start = 1'b0;
    rd_start = 1'b0;
    checks++; if (pops !== 0) begin errors++; $display("FAIL wr_in_rd_pops: got %0d want 0", pops); end
    checks++; if (err_collision !== 1'b1) begin errors++; $display("FAIL wr_in_rd_err: got %b want 1", err_collision); end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_reset_mid_write();
    apply_reset();
    test_write();
    test_reads(-1, 1'b0, 1'b0, 1'b0);
    test_reads(BL, 1'b1, 1'b0, 1'b0);
    test_reads(2, 1'b0, 1'b0, 1'b1);
    apply_reset();
    test_reads(-1, 1'b0, 1'b1, 1'b1);
    apply_reset();
    test_wr_during_read();
    apply_reset();
    test_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
